// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: reset/lock sequencer and divider-select driver for the
// GW1NR-9 rPLL with dynamic IDIV/FBDIV/ODIV selects. Runs on the board clock.
// Lock is qualified by a stability window, retried on timeout, and parked in
// FAIL (PLL held in reset) after too many failed attempts.
module pll_reconfig_ctrl #(
  parameter int INIT_IDIV    = 2,
  parameter int INIT_FBDIV   = 0,
  parameter int INIT_ODIV    = 48,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idiv,
  input  logic [5:0] req_fbdiv,
  input  logic [5:0] req_odiv,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       busy,
  output logic       err
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] ST_LIMIT  = SW'(LOCK_STABLE);
  localparam logic [RW-1:0] RT_LIMIT  = RW'(MAX_RETRY);

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odiv;
  } div_codes_t;

  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

  localparam div_codes_t INIT_CODES = {6'(INIT_IDIV), 6'(INIT_FBDIV), 6'(INIT_ODIV)};

  state_t          state_q, state_n;
  div_codes_t      codes_q, codes_n;
  logic [HW-1:0]   hold_q, hold_n;
  logic [TW-1:0]   to_q, to_n;
  logic [SW-1:0]   st_q, st_n;
  logic [RW-1:0]   retry_q, retry_n;
  logic            lock_meta, lock_s;
  logic            timeout, accept;

  // Two-flop synchronizer for the asynchronous PLL LOCK
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State, divider codes and sequence counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLD;
      codes_q <= INIT_CODES;
      hold_q  <= '0;
      to_q    <= '0;
      st_q    <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_n;
      codes_q <= codes_n;
      hold_q  <= hold_n;
      to_q    <= to_n;
      st_q    <= st_n;
      retry_q <= retry_n;
    end
  end

  // Next state and counter updates; an accepted request overrides everything
  always_comb begin
    state_n = state_q;
    codes_n = codes_q;
    hold_n  = hold_q;
    to_n    = to_q;
    st_n    = st_q;
    retry_n = retry_q;
    // Deadline is hit on the cycle whose increment lands on LOCK_TIMEOUT;
    // it takes priority over any lock progress made on that same cycle.
    timeout = ((to_q + TW'(1)) == TO_LIMIT);
    accept  = req_valid && (state_q == S_RUN || state_q == S_FAIL);
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_n = S_WAIT;
          to_n    = '0;
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
      S_WAIT, S_STABLE: begin
        to_n = to_q + TW'(1);
        if (timeout) begin
          retry_n = retry_q + RW'(1);
          hold_n  = '0;
          state_n = ((retry_q + RW'(1)) < RT_LIMIT) ? S_HOLD : S_FAIL;
        end else if (state_q == S_WAIT) begin
          if (lock_s) begin
            state_n = S_STABLE;
            st_n    = '0;
          end
        end else if (!lock_s) begin
          state_n = S_WAIT;
        end else if ((st_q + SW'(1)) == ST_LIMIT) begin
          state_n = S_RUN;
          retry_n = '0;
        end else begin
          st_n = st_q + SW'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_n = S_HOLD;
          hold_n  = '0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      codes_n = {req_idiv, req_fbdiv, req_odiv};
      state_n = S_HOLD;
      hold_n  = '0;
      retry_n = '0;
    end
  end

  // Outputs decoded from state; selects are the inverted stored codes
  always_comb begin
    pll_reset  = 1'b0;
    locked     = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      S_HOLD:           begin pll_reset = 1'b1; busy = 1'b1; end
      S_WAIT, S_STABLE: busy = 1'b1;
      S_RUN:            begin locked = 1'b1; req_ready = 1'b1; end
      S_FAIL:           begin err = 1'b1; pll_reset = 1'b1; req_ready = 1'b1; end
      default: ;
    endcase
    pll_idsel  = ~codes_q.idiv;
    pll_fbdsel = ~codes_q.fbdiv;
    pll_odsel  = ~codes_q.odiv;
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a small rPLL lock model.
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [5:0] req_idiv = '0, req_fbdiv = '0, req_odiv = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, busy, err;

  int n_cmp = 0;
  int n_err = 0;
  int pll_mode = 0;   // 0: lock 3 cycles after reset release, 1: chatter, 2: forced low
  int rcnt = 0;
  int ccnt = 0;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .INIT_IDIV(2), .INIT_FBDIV(0), .INIT_ODIV(48),
    .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_odiv(req_odiv),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .locked(locked), .busy(busy), .err(err)
  );

  // PLL model, updated on the falling edge so LOCK is asynchronous-looking
  always @(negedge clk) begin
    if (pll_mode == 1) begin
      ccnt++;
      if (ccnt >= 5) begin ccnt = 0; pll_lock = ~pll_lock; end
    end else if (pll_mode == 2 || pll_reset) begin
      rcnt = 0;
      pll_lock = 1'b0;
    end else begin
      if (rcnt < 3) rcnt++;
      if (rcnt == 3) pll_lock = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
    req_idiv = i; req_fbdiv = f; req_odiv = o; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", busy); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (pll_idsel !== 6'h3D) begin n_err++; $display("FAIL reset_idsel: got %h want 3d", pll_idsel); end
    n_cmp++; if (pll_fbdsel !== 6'h3F) begin n_err++; $display("FAIL reset_fbdsel: got %h want 3f", pll_fbdsel); end
    n_cmp++; if (pll_odsel !== 6'h0F) begin n_err++; $display("FAIL reset_odsel: got %h want 0f", pll_odsel); end
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    int n, k;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_reset) n++; else break;
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL bringup_reset_len: got %0d want 4", n); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bringup_busy_wait: got %b want 1", busy); end
    k = 0;
    while (!pll_lock && k < 50) begin tick(); k++; end
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL bringup_lock_latency: got %0d want 10", n); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bringup_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bringup_busy: got %b want 0", busy); end
    n_cmp++; if (pll_idsel !== 6'h3D) begin n_err++; $display("FAIL bringup_idsel: got %h want 3d", pll_idsel); end
  endtask

  task automatic test_request();
    int n, k, rdy_bad;
    send_req(6'd1, 6'd3, 6'd16);
    n_cmp++; if (pll_idsel !== 6'h3E) begin n_err++; $display("FAIL req_idsel: got %h want 3e", pll_idsel); end
    n_cmp++; if (pll_fbdsel !== 6'h3C) begin n_err++; $display("FAIL req_fbdsel: got %h want 3c", pll_fbdsel); end
    n_cmp++; if (pll_odsel !== 6'h2F) begin n_err++; $display("FAIL req_odsel: got %h want 2f", pll_odsel); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL req_ready_drop: got %b want 0", req_ready); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL req_locked_drop: got %b want 0", locked); end
    n = pll_reset ? 1 : 0;
    // a request while busy must be ignored
    send_req(6'd7, 6'd7, 6'd7);
    if (pll_reset) n++;
    n_cmp++; if (pll_idsel !== 6'h3E) begin n_err++; $display("FAIL req_ignored_busy: got %h want 3e", pll_idsel); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_reset) n++; else break;
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL req_reset_len: got %0d want 4", n); end
    k = 0; rdy_bad = 0;
    while (!locked && k < 200) begin
      if (req_ready) rdy_bad++;
      tick(); k++;
    end
    n_cmp++; if (rdy_bad !== 0) begin n_err++; $display("FAIL req_ready_early: got %0d cycles want 0", rdy_bad); end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL req_relock: got %b want 1", locked); end
    n_cmp++; if (pll_odsel !== 6'h2F) begin n_err++; $display("FAIL req_odsel_kept: got %h want 2f", pll_odsel); end
  endtask

  task automatic test_lost_lock();
    int n, k;
    pll_mode = 2;
    n = 0;
    while (locked && n < 20) begin tick(); n++; end
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL lost_latency: got %0d want 3", n); end
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL lost_pll_reset: got %b want 1", pll_reset); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL lost_busy: got %b want 1", busy); end
    n_cmp++; if (pll_idsel !== 6'h3E) begin n_err++; $display("FAIL lost_idsel: got %h want 3e", pll_idsel); end
    n_cmp++; if (pll_fbdsel !== 6'h3C) begin n_err++; $display("FAIL lost_fbdsel: got %h want 3c", pll_fbdsel); end
    pll_mode = 0;
    k = 0;
    while (!locked && k < 200) begin tick(); k++; end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lost_relock: got %b want 1", locked); end
  endtask

  task automatic test_lost_lock_req();
    int k;
    pll_mode = 2;
    tick(); tick();
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lostreq_still_run: got %b want 1", locked); end
    send_req(6'd5, 6'd7, 6'd9);
    n_cmp++; if (pll_idsel !== 6'h3A) begin n_err++; $display("FAIL lostreq_idsel: got %h want 3a", pll_idsel); end
    n_cmp++; if (pll_fbdsel !== 6'h38) begin n_err++; $display("FAIL lostreq_fbdsel: got %h want 38", pll_fbdsel); end
    n_cmp++; if (pll_odsel !== 6'h36) begin n_err++; $display("FAIL lostreq_odsel: got %h want 36", pll_odsel); end
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL lostreq_pll_reset: got %b want 1", pll_reset); end
    pll_mode = 0;
    k = 0;
    while (!locked && k < 200) begin tick(); k++; end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lostreq_relock: got %b want 1", locked); end
  endtask

  task automatic test_chatter();
    int n, lows, lk;
    pll_mode = 1;
    send_req(6'd4, 6'd4, 6'd4);
    n = 1; lows = 0; lk = 0;
    while (!err && n < 200) begin
      tick(); n++;
      if (!pll_reset) lows++;
      if (locked) lk++;
    end
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL chatter_fail_time: got %0d want 49", n); end
    n_cmp++; if (lows !== 40) begin n_err++; $display("FAIL chatter_wait_cycles: got %0d want 40", lows); end
    n_cmp++; if (lk !== 0) begin n_err++; $display("FAIL chatter_locked_seen: got %0d want 0", lk); end
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL fail_pll_reset: got %b want 1", pll_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fail_busy: got %b want 0", busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fail_req_ready: got %b want 1", req_ready); end
    repeat (5) tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL fail_sticky: got %b want 1", err); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL fail_locked: got %b want 0", locked); end
  endtask

  task automatic test_fail_recovery();
    int k;
    pll_mode = 0;
    tick();
    send_req(6'd2, 6'd0, 6'd48);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL recov_err_clear: got %b want 0", err); end
    n_cmp++; if (pll_idsel !== 6'h3D) begin n_err++; $display("FAIL recov_idsel: got %h want 3d", pll_idsel); end
    n_cmp++; if (pll_odsel !== 6'h0F) begin n_err++; $display("FAIL recov_odsel: got %h want 0f", pll_odsel); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL recov_busy: got %b want 1", busy); end
    k = 0;
    while (!locked && k < 200) begin tick(); k++; end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL recov_locked: got %b want 1", locked); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL recov_err_low: got %b want 0", err); end
  endtask

  task automatic test_rst_midseq();
    int n, k;
    send_req(6'd1, 6'd3, 6'd16);
    k = 0;
    while (pll_reset && k < 20) begin tick(); k++; end
    tick(); tick();
    n_cmp++; if (!(busy === 1'b1 && pll_reset === 1'b0)) begin n_err++; $display("FAIL rst_in_wait: got busy=%b pll_reset=%b want 1/0", busy, pll_reset); end
    rst = 1'b1;
    tick();
    n_cmp++; if (pll_idsel !== 6'h3D) begin n_err++; $display("FAIL rst_idsel: got %h want 3d", pll_idsel); end
    n_cmp++; if (pll_fbdsel !== 6'h3F) begin n_err++; $display("FAIL rst_fbdsel: got %h want 3f", pll_fbdsel); end
    n_cmp++; if (pll_odsel !== 6'h0F) begin n_err++; $display("FAIL rst_odsel: got %h want 0f", pll_odsel); end
    n_cmp++; if (pll_reset !== 1'b1) begin n_err++; $display("FAIL rst_pll_reset: got %b want 1", pll_reset); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    rst = 1'b0;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_reset) n++; else break;
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL rst_reset_len: got %0d want 4", n); end
    k = 0;
    while (!pll_lock && k < 50) begin tick(); k++; end
    n = 0;
    while (!locked && n < 100) begin tick(); n++; end
    n_cmp++; if (n !== 10) begin n_err++; $display("FAIL rst_lock_latency: got %0d want 10", n); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_request();
    test_lost_lock();
    test_lost_lock_req();
    test_chatter();
    test_fail_recovery();
    test_rst_midseq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
